// File: rtl/pktbuf_pkg.sv
// pktbuf_pkg: shared mode, FSM state and port-index definitions for the packet buffer.
package pktbuf_pkg;

    typedef enum logic [1:0] {
        MODE_BUS = 2'b00,
        MODE_DMA = 2'b01,
        MODE_ETH = 2'b10,
        MODE_ARB = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_WAIT   = 2'b10,
        S_ACK    = 2'b11
    } state_t;

    localparam logic [1:0] P_BUS = 2'd0;
    localparam logic [1:0] P_DMA = 2'd1;
    localparam logic [1:0] P_ETH = 2'd2;

endpackage

// File: rtl/pktbuf_ram.sv
// pktbuf_ram: single-port 16-bit buffer storage with synchronous read and byte enables.
module pktbuf_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] adr,
    input  logic [15:0]   wdat,
    output logic [15:0]   rdat
);

    logic [15:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we && be[0]) mem[adr][7:0] <= wdat[7:0];
            if (we && be[1]) mem[adr][15:8] <= wdat[15:8];
            rdat <= mem[adr];
        end
    end

endmodule

// File: rtl/pktbuf.sv
// pktbuf: three-port (bus/DMA/Ethernet) packet buffer with mode-selected ownership.
// Define PKTBUF_RR_ARB_EN to enable round-robin arbitration in mode 11 (otherwise mode 11 acts as mode 00).
module pktbuf
    import pktbuf_pkg::*;
#(
    parameter int AW     = 10,
    parameter int ACK_WS = 0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [15:0]   wb_dat_i,
    output logic [15:0]   wb_dat_o,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [1:0]    wb_sel_i,
    output logic          wb_ack_o,
    input  logic          dma_req_i,
    input  logic [AW-1:0] dma_adr_i,
    input  logic [15:0]   dma_dat_i,
    input  logic          dma_we_i,
    output logic [15:0]   dma_dat_o,
    output logic          dma_ack_o,
    input  logic          eth_req_i,
    input  logic [AW-1:0] eth_adr_i,
    input  logic [15:0]   eth_dat_i,
    input  logic          eth_we_i,
    output logic [15:0]   eth_dat_o,
    output logic          eth_ack_o,
    input  logic [1:0]    mode_i,
    input  logic          clr_i,
    output logic [AW:0]   wr_cnt_o,
    output logic          full_o
);

    state_t        state;
    logic [1:0]    gnt;
    logic          we_r;
    logic [1:0]    sel_r;
    logic [AW-1:0] adr_r;
    logic [15:0]   dat_r;
    logic [1:0]    ws_cnt;
    logic [15:0]   ram_q;
    logic [15:0]   wb_q;
    logic [15:0]   dma_q;
    logic [15:0]   eth_q;
    logic [2:0]    req;
    logic [1:0]    pick;
    logic          pick_ok;
    logic [AW-1:0] s_adr;
    logic [15:0]   s_dat;
    logic          s_we;
    logic [1:0]    s_sel;
    logic          ws_done;
    logic          go_ack;
    logic          rd_ack;

    assign req = {eth_req_i, dma_req_i, wb_cyc_i & wb_stb_i};

`ifdef PKTBUF_RR_ARB_EN
    logic [1:0] last;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] rr;
    // Candidates in priority order after the last granted port, which ends up last.
    assign c1 = last == P_ETH ? P_BUS : last + 2'd1;
    assign c2 = c1 == P_ETH ? P_BUS : c1 + 2'd1;
    assign rr = req[c1] ? c1 : req[c2] ? c2 : last;
`endif

    always_comb begin
        pick = mode_i == MODE_DMA ? P_DMA : mode_i == MODE_ETH ? P_ETH : P_BUS;
`ifdef PKTBUF_RR_ARB_EN
        if (mode_i == MODE_ARB) pick = rr;
`endif
    end

    assign pick_ok = req[pick];
    assign s_adr   = pick == P_DMA ? dma_adr_i : pick == P_ETH ? eth_adr_i : wb_adr_i;
    assign s_dat   = pick == P_DMA ? dma_dat_i : pick == P_ETH ? eth_dat_i : wb_dat_i;
    assign s_we    = pick == P_DMA ? dma_we_i  : pick == P_ETH ? eth_we_i  : wb_we_i;
    assign s_sel   = pick == P_BUS ? wb_sel_i : 2'b11;
    assign ws_done = int'(ws_cnt) + 1 >= ACK_WS;
    assign go_ack  = req[gnt] && (state == S_ACCESS ? ACK_WS == 0 : state == S_WAIT && ws_done);
    assign full_o  = wr_cnt_o == {1'b1, {AW{1'b0}}};
    assign rd_ack  = state == S_ACK && !we_r;

    // The RAM output register is the read data during ACK; afterwards each port keeps its own copy.
    assign wb_dat_o  = rd_ack && gnt == P_BUS ? ram_q : wb_q;
    assign dma_dat_o = rd_ack && gnt == P_DMA ? ram_q : dma_q;
    assign eth_dat_o = rd_ack && gnt == P_ETH ? ram_q : eth_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= S_IDLE;
            gnt       <= P_BUS;
            we_r      <= 1'b0;
            sel_r     <= 2'b00;
            adr_r     <= '0;
            dat_r     <= '0;
            ws_cnt    <= '0;
            wb_ack_o  <= 1'b0;
            dma_ack_o <= 1'b0;
            eth_ack_o <= 1'b0;
            wb_q      <= '0;
            dma_q     <= '0;
            eth_q     <= '0;
            wr_cnt_o  <= '0;
`ifdef PKTBUF_RR_ARB_EN
            last      <= P_ETH;
`endif
        end else begin
            wb_ack_o  <= go_ack && gnt == P_BUS;
            dma_ack_o <= go_ack && gnt == P_DMA;
            eth_ack_o <= go_ack && gnt == P_ETH;
            if (go_ack && we_r) wr_cnt_o <= clr_i ? (AW+1)'(1) : full_o ? wr_cnt_o : wr_cnt_o + 1'b1;
            else if (clr_i) wr_cnt_o <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_ok) begin
                        state <= S_ACCESS;
                        gnt   <= pick;
                        adr_r <= s_adr;
                        dat_r <= s_dat;
                        we_r  <= s_we;
                        sel_r <= s_sel;
`ifdef PKTBUF_RR_ARB_EN
                        if (mode_i == MODE_ARB) last <= pick;
`endif
                    end
                end
                S_ACCESS: begin
                    ws_cnt <= '0;
                    state  <= !req[gnt] ? S_IDLE : ACK_WS == 0 ? S_ACK : S_WAIT;
                end
                S_WAIT: begin
                    ws_cnt <= ws_cnt + 2'd1;
                    state  <= !req[gnt] ? S_IDLE : ws_done ? S_ACK : S_WAIT;
                end
                S_ACK: begin
                    state <= S_IDLE;
                    if (!we_r) begin
                        wb_q  <= gnt == P_BUS ? ram_q : wb_q;
                        dma_q <= gnt == P_DMA ? ram_q : dma_q;
                        eth_q <= gnt == P_ETH ? ram_q : eth_q;
                    end
                end
            endcase
        end
    end

    pktbuf_ram #(.AW(AW)) u_ram (
        .clk  (wb_clk_i),
        .en   (state == S_ACCESS),
        .we   (we_r),
        .be   (sel_r),
        .adr  (adr_r),
        .wdat (dat_r),
        .rdat (ram_q)
    );

endmodule

// File: tb/tb_pktbuf.sv
// tb_pktbuf: directed, table-driven bench; dut_a uses defaults, dut_b uses AW=4, ACK_WS=3 on shared inputs.
module tb_pktbuf;
    import pktbuf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  wb_adr, dma_adr, eth_adr;
    logic [15:0] wb_dat, dma_dat, eth_dat;
    logic        wb_cyc, wb_stb, wb_we, dma_req, dma_we, eth_req, eth_we, clr;
    logic [1:0]  wb_sel, mode;

    logic [15:0] a_wb_dat, a_dma_dat, a_eth_dat, b_wb_dat, b_dma_dat, b_eth_dat;
    logic        a_wb_ack, a_dma_ack, a_eth_ack, b_wb_ack, b_dma_ack, b_eth_ack;
    logic [10:0] a_cnt;
    logic [4:0]  b_cnt;
    logic        a_full, b_full;

    int cmp = 0;
    int bad = 0;

    pktbuf dut_a (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(a_wb_dat), .wb_cyc_i(wb_cyc),
        .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_ack_o(a_wb_ack),
        .dma_req_i(dma_req), .dma_adr_i(dma_adr), .dma_dat_i(dma_dat), .dma_we_i(dma_we),
        .dma_dat_o(a_dma_dat), .dma_ack_o(a_dma_ack),
        .eth_req_i(eth_req), .eth_adr_i(eth_adr), .eth_dat_i(eth_dat), .eth_we_i(eth_we),
        .eth_dat_o(a_eth_dat), .eth_ack_o(a_eth_ack),
        .mode_i(mode), .clr_i(clr), .wr_cnt_o(a_cnt), .full_o(a_full)
    );

    pktbuf #(.AW(4), .ACK_WS(3)) dut_b (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wb_adr_i(wb_adr[3:0]), .wb_dat_i(wb_dat), .wb_dat_o(b_wb_dat), .wb_cyc_i(wb_cyc),
        .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_ack_o(b_wb_ack),
        .dma_req_i(dma_req), .dma_adr_i(dma_adr[3:0]), .dma_dat_i(dma_dat), .dma_we_i(dma_we),
        .dma_dat_o(b_dma_dat), .dma_ack_o(b_dma_ack),
        .eth_req_i(eth_req), .eth_adr_i(eth_adr[3:0]), .eth_dat_i(eth_dat), .eth_we_i(eth_we),
        .eth_dat_o(b_eth_dat), .eth_ack_o(b_eth_ack),
        .mode_i(mode), .clr_i(clr), .wr_cnt_o(b_cnt), .full_o(b_full)
    );

    typedef struct {
        logic [1:0]  mode;
        int          p;
        logic        we;
        logic [9:0]  a;
        logic [15:0] d;
        logic [1:0]  s;
        logic [15:0] exp_rd;
        logic [10:0] exp_cnt;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic ack_of(input int p, input int w);
        if (w == 0) return p == 0 ? a_wb_ack : p == 1 ? a_dma_ack : a_eth_ack;
        return p == 0 ? b_wb_ack : p == 1 ? b_dma_ack : b_eth_ack;
    endfunction

    function automatic logic [15:0] dat_of(input int p, input int w);
        if (w == 0) return p == 0 ? a_wb_dat : p == 1 ? a_dma_dat : a_eth_dat;
        return p == 0 ? b_wb_dat : p == 1 ? b_dma_dat : b_eth_dat;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drop();
        wb_cyc = 1'b0; wb_stb = 1'b0; dma_req = 1'b0; eth_req = 1'b0;
    endtask

    task automatic raise(input int p, input logic we, input logic [9:0] a, input logic [15:0] d, input logic [1:0] s);
        case (p)
            0: begin wb_adr = a; wb_dat = d; wb_we = we; wb_sel = s; wb_cyc = 1'b1; wb_stb = 1'b1; end
            1: begin dma_adr = a; dma_dat = d; dma_we = we; dma_req = 1'b1; end
            default: begin eth_adr = a; eth_dat = d; eth_we = we; eth_req = 1'b1; end
        endcase
    endtask

    task automatic wait_ack(input int p, input int w, output int lat, output logic [15:0] rd);
        lat = 0;
        rd = '0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ack_of(p, w)) begin
                lat = n;
                rd = dat_of(p, w);
                break;
            end
        end
    endtask

    task automatic xfer(input int p, input logic we, input logic [9:0] a, input logic [15:0] d,
                        input logic [1:0] s, input int w, output int lat, output logic [15:0] rd);
        raise(p, we, a, d, s);
        wait_ack(p, w, lat, rd);
        drop();
        tick();
    endtask

    initial begin
        int lat;
        int acks;
        int k;
        int got[6];
        logic [15:0] rd;

        wb_adr = '0; dma_adr = '0; eth_adr = '0; wb_dat = '0; dma_dat = '0; eth_dat = '0;
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 2'b11; dma_req = 0; dma_we = 0;
        eth_req = 0; eth_we = 0; clr = 0; mode = 2'b00;

        tv[0]  = '{2'b00, 0, 1'b1, 10'h007, 16'hA5A5, 2'b11, 16'h0000, 11'd2};
        tv[1]  = '{2'b00, 0, 1'b1, 10'h007, 16'h1200, 2'b10, 16'h0000, 11'd3};
        tv[2]  = '{2'b00, 0, 1'b0, 10'h007, 16'h0000, 2'b11, 16'h12A5, 11'd3};
        tv[3]  = '{2'b00, 0, 1'b1, 10'h3FF, 16'hBEEF, 2'b11, 16'h0000, 11'd4};
        tv[4]  = '{2'b00, 0, 1'b0, 10'h3FF, 16'h0000, 2'b11, 16'hBEEF, 11'd4};
        tv[5]  = '{2'b01, 1, 1'b1, 10'h020, 16'hCAFE, 2'b00, 16'h0000, 11'd5};
        tv[6]  = '{2'b10, 2, 1'b0, 10'h020, 16'h0000, 2'b00, 16'hCAFE, 11'd5};
        tv[7]  = '{2'b01, 1, 1'b0, 10'h007, 16'h0000, 2'b00, 16'h12A5, 11'd5};
        tv[8]  = '{2'b00, 0, 1'b0, 10'h020, 16'h0000, 2'b11, 16'hCAFE, 11'd5};
        tv[9]  = '{2'b10, 2, 1'b1, 10'h005, 16'h0000, 2'b00, 16'h0000, 11'd6};
        tv[10] = '{2'b00, 0, 1'b0, 10'h005, 16'h0000, 2'b11, 16'h0000, 11'd6};

        #1;
        chk("rst_ack", {a_wb_ack, a_dma_ack, a_eth_ack, b_wb_ack, b_dma_ack, b_eth_ack}, 0);
        chk("rst_dat", {a_wb_dat, a_dma_dat}, 0);
        chk("rst_cnt", {a_cnt, b_cnt, a_full, b_full}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        xfer(0, 1'b1, 10'd5, 16'h1234, 2'b11, 0, lat, rd);
        chk("bus_wr_lat", lat, 2);
        chk("bus_wr_cnt", a_cnt, 1);
        xfer(0, 1'b0, 10'd5, 16'h0000, 2'b11, 0, lat, rd);
        chk("bus_rd_lat", lat, 2);
        chk("bus_rd_dat", rd, 16'h1234);
        chk("bus_rd_cnt", a_cnt, 1);

        for (int i = 0; i < 11; i++) begin
            mode = tv[i].mode;
            xfer(tv[i].p, tv[i].we, tv[i].a, tv[i].d, tv[i].s, 0, lat, rd);
            chk($sformatf("tv%0d_lat", i), lat, 2);
            if (!tv[i].we) chk($sformatf("tv%0d_dat", i), rd, tv[i].exp_rd);
            chk($sformatf("tv%0d_cnt", i), a_cnt, tv[i].exp_cnt);
        end
        chk("hold_dma", a_dma_dat, 16'h12A5);
        chk("hold_eth", a_eth_dat, 16'hCAFE);
        chk("hold_wb", a_wb_dat, 16'h0000);

        mode = 2'b00;
        dma_we = 1'b1; eth_we = 1'b1; dma_req = 1'b1; eth_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_dma_ack || a_eth_ack) acks++;
        end
        drop();
        idle(2);
        chk("nonowner_ack", acks, 0);
        chk("nonowner_cnt", a_cnt, 6);

        raise(0, 1'b0, 10'd5, 16'h0000, 2'b11);
        tick();
        mode = 2'b01;
        raise(1, 1'b0, 10'd7, 16'h0000, 2'b00);
        tick();
        chk("mode_mid_wb_ack", a_wb_ack, 1);
        chk("mode_mid_dma_ack", a_dma_ack, 0);
        drop();
        idle(3);

        mode = 2'b11;
        raise(0, 1'b0, 10'd5, 16'h0, 2'b11);
        raise(1, 1'b0, 10'd7, 16'h0, 2'b00);
        raise(2, 1'b0, 10'h20, 16'h0, 2'b00);
        for (int i = 0; i < 6; i++) got[i] = -1;
        k = 0;
        for (int n = 0; n < 40 && k < 6; n++) begin
            tick();
            if (a_wb_ack) begin got[k] = 0; k++; end
            else if (a_dma_ack) begin got[k] = 1; k++; end
            else if (a_eth_ack) begin got[k] = 2; k++; end
        end
        drop();
        idle(4);
        for (int i = 0; i < 6; i++) begin
`ifdef PKTBUF_RR_ARB_EN
            chk($sformatf("rr_grant%0d", i), got[i], i % 3);
`else
            chk($sformatf("rr_grant%0d", i), got[i], 0);
`endif
        end

        mode = 2'b00;
        idle(6);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_b_cnt", b_cnt, 0);

        mode = 2'b10;
        for (int i = 0; i < 17; i++) begin
            xfer(2, 1'b1, 10'(i), 16'(i * 3), 2'b11, 1, lat, rd);
            chk($sformatf("eth%0d_lat", i), lat, 5);
            chk($sformatf("eth%0d_cnt", i), b_cnt, i < 16 ? i + 1 : 16);
            chk($sformatf("eth%0d_full", i), b_full, i >= 15);
        end
        raise(2, 1'b1, 10'd1, 16'h5555, 2'b11);
        clr = 1'b1;
        wait_ack(2, 1, lat, rd);
        clr = 1'b0;
        drop();
        tick();
        chk("clr_wr_lat", lat, 5);
        chk("clr_wr_cnt", b_cnt, 1);
        chk("clr_wr_full", b_full, 0);
        idle(4);

        mode = 2'b00;
        xfer(0, 1'b1, 10'd3, 16'h0000, 2'b11, 1, lat, rd);
        chk("sel_init_lat", lat, 5);
        xfer(0, 1'b1, 10'd3, 16'hABCD, 2'b01, 1, lat, rd);
        chk("sel_wr_lat", lat, 5);
        xfer(0, 1'b0, 10'd3, 16'h0000, 2'b11, 1, lat, rd);
        chk("sel_rd_lat", lat, 5);
        chk("sel_rd_dat", rd, 16'h00CD);
        idle(4);

        raise(0, 1'b0, 10'd3, 16'h0000, 2'b11);
        tick();
        tick();
        wb_stb = 1'b0;
        tick();
        chk("abort_idle", dut_b.state, S_IDLE);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (b_wb_ack) acks++;
            tick();
        end
        drop();
        chk("abort_noack", acks, 0);
        chk("abort_hold", b_wb_dat, 16'h00CD);
        chk("abort_cnt", b_cnt, 3);
        idle(4);

        raise(0, 1'b1, 10'd9, 16'h9999, 2'b11);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstmid_ack", {a_wb_ack, b_wb_ack}, 0);
        chk("rstmid_cnt", {a_cnt, b_cnt}, 0);
        chk("rstmid_full", b_full, 0);
        drop();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstrel_idle", dut_b.state, S_IDLE);
        chk("rstrel_dat", b_wb_dat, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule

// File: doc/pktbuf.md
PKTBUF -- requirements
Module: pktbuf

Interface
REQ-001 SHALL provide parameter AW, default 10, meaning buffer word-address width (depth 2**AW words of 16 bits).
REQ-002 SHALL provide parameter ACK_WS, default 0, meaning extra wait states before acknowledge (range 0..3).
REQ-003 SHALL use one clock and an asynchronous active-low reset: wb_clk_i in 1 clock; wb_rst_n_i in 1, asynchronous active-low reset.
REQ-004 SHALL have wb_adr_i in AW, wb_dat_i in 16, wb_dat_o out 16, wb_cyc_i in 1, wb_stb_i in 1, wb_we_i in 1, wb_sel_i in 2, wb_ack_o out 1, forming the processor bus port.
REQ-005 SHALL have dma_req_i in 1, dma_adr_i in AW, dma_dat_i in 16, dma_we_i in 1, dma_dat_o out 16, dma_ack_o out 1, forming the DMA port.
REQ-006 SHALL have eth_req_i in 1, eth_adr_i in AW, eth_dat_i in 16, eth_we_i in 1, eth_dat_o out 16, eth_ack_o out 1, forming the Ethernet port.
REQ-007 SHALL have mode_i in 2 (00 bus, 01 DMA, 10 Ethernet, 11 arbitrated), clr_i in 1, wr_cnt_o out AW+1, full_o out 1.

Function
REQ-008 SHALL implement FSM IDLE -> ACCESS -> WAIT (ACK_WS cycles, skipped when 0) -> ACK -> IDLE.
REQ-009 IDLE SHALL sample requests and mode_i on the clock edge; bus request = wb_cyc_i & wb_stb_i.
REQ-010 In modes 00/01/10, only the owning port SHALL be granted; other requests are ignored and never acknowledged.
REQ-011 Mode 11 SHALL grant round-robin among bus, DMA, Ethernet; last granted port becomes lowest priority.
REQ-012 ACCESS SHALL present the granted port's address/data to RAM for exactly one cycle; a write occurs only in ACCESS.
REQ-013 Bus writes SHALL honour wb_sel_i byte lanes; DMA/Ethernet writes are full-word.
REQ-014 Read data SHALL be registered and valid on the granted port's *_dat_o in the ACK cycle; it holds until the next read by that port.
REQ-015 Ack SHALL be a one-cycle pulse on the granted port only, occurring ACK_WS+2 cycles after the IDLE sampling edge.
REQ-016 Request dropped before ACK: ack suppressed and FSM returns to IDLE; a write already performed in ACCESS stands.
REQ-017 mode_i change mid-transaction SHALL take effect only at the next IDLE.
REQ-018 wr_cnt_o SHALL increment per completed write from any port, saturate at 2**AW; full_o = (wr_cnt_o == 2**AW).
REQ-019 clr_i SHALL zero wr_cnt_o; clr_i together with a write yields 1.
REQ-020 Addresses SHALL wrap modulo 2**AW; no out-of-range access exists.

Reset
REQ-021 Reset SHALL force FSM IDLE, all acks 0, all *_dat_o 0, wr_cnt_o 0, full_o 0, round-robin pointer = bus highest; RAM contents undefined.
REQ-022 Reset mid-transaction SHALL abort without ack; a pending write may or may not have been stored.

Configuration
REQ-023 Macro PKTBUF_RR_ARB_EN defined: mode 11 SHALL arbitrate per REQ-011.
REQ-024 Macro PKTBUF_RR_ARB_EN undefined: round-robin logic absent; mode 11 SHALL behave as mode 00.

Structure
REQ-025 Mode encodings, FSM state encoding and port-index constants SHALL reside in shared package pktbuf_pkg.
REQ-026 Storage SHALL be sub-module pktbuf_ram (single-port, synchronous read, byte enables, depth 2**AW).

Verification
REQ-027 Mode 00, ACK_WS=0, bus write 16'h1234 to 5 then read 5 -> wb_ack_o at cycle 2 of each, wb_dat_o=16'h1234, wr_cnt_o=1.
REQ-028 Mode 00, dma_req_i and eth_req_i held 20 cycles -> no dma_ack_o/eth_ack_o, wr_cnt_o unchanged.
REQ-029 Mode 11, all three requesting continuously -> grants bus, DMA, Ethernet, bus, ... ; macro undefined -> only bus acked.
REQ-030 AW=4, 17 Ethernet writes -> wr_cnt_o=16, full_o=1 after 16th, stays 16; clr_i with 18th write -> wr_cnt_o=1.
REQ-031 ACK_WS=3, bus read with wb_stb_i dropped in WAIT -> no ack, FSM IDLE next cycle; bus write wb_sel_i=2'b01 of 16'hABCD over 16'h0000 -> reads 16'h00CD.
REQ-032 wb_rst_n_i low during WAIT -> all acks 0 and wr_cnt_o 0 immediately, FSM IDLE on release.
